// File: rtl/lagd_mem_bank_ctrl.sv
// Per-bank SRAM controller: valid/ready word requests become single-cycle macro strobes, and
// responses return in order through a credit-protected FIFO.
module lagd_mem_bank_ctrl #(
    parameter int unsigned AddrWidth         = 11,
    parameter int unsigned WordsPerBank      = 2048,
    parameter int unsigned DataWidth         = 64,
    parameter int unsigned BankAccessLatency = 1,
    parameter int unsigned RspFifoDepth      = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [AddrWidth-1:0]   req_addr_i,
    input  logic                   req_we_i,
    input  logic [DataWidth-1:0]   req_wdata_i,
    input  logic [DataWidth/8-1:0] req_strb_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [DataWidth-1:0]   rsp_rdata_o,
    output logic                   rsp_write_o,
    output logic                   rsp_err_o,
    output logic                   sram_req_o,
    output logic                   sram_we_o,
    output logic [AddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]   sram_wdata_o,
    output logic [DataWidth/8-1:0] sram_be_o,
    input  logic [DataWidth-1:0]   sram_rdata_i
);

    localparam int unsigned Lat      = BankAccessLatency;
    localparam int unsigned PtrWidth = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int unsigned CntWidth = $clog2(RspFifoDepth + 1);
    localparam logic [AddrWidth:0]      AddrLimit = (AddrWidth + 1)'(WordsPerBank);
    localparam logic [PtrWidth-1:0]     LastPtr   = PtrWidth'(RspFifoDepth - 1);

    if (BankAccessLatency == 0) begin : g_err_lat
        $error("BankAccessLatency must be at least 1");
    end
    if (RspFifoDepth == 0) begin : g_err_depth
        $error("RspFifoDepth must be at least 1");
    end
    if (64'(WordsPerBank) > (64'(1) << AddrWidth)) begin : g_err_words
        $error("WordsPerBank exceeds the address space");
    end
    if ((DataWidth % 8) != 0) begin : g_err_width
        $error("DataWidth must be a multiple of 8");
    end

    logic                   r_ready;
    logic [Lat-1:0]         r_pipe_vld, r_pipe_we, r_pipe_err;
    logic [DataWidth-1:0]   r_fifo_data [RspFifoDepth];
    logic [RspFifoDepth-1:0] r_fifo_we, r_fifo_err;
    logic [PtrWidth-1:0]    r_wptr, r_rptr;
    logic [CntWidth-1:0]    r_count;

    logic                   w_accept, w_in_range, w_push, w_pop, w_ready_d;
    logic [Lat-1:0]         w_pipe_vld_d, w_pipe_we_d, w_pipe_err_d;
    logic [CntWidth-1:0]    w_count_d;
    logic [DataWidth-1:0]   w_push_data;
    int unsigned            w_occ_d;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    assign w_accept   = req_valid_i & r_ready;
    assign w_in_range = {1'b0, req_addr_i} < AddrLimit;
    assign w_push     = r_pipe_vld[Lat-1];
    assign w_pop      = rsp_valid_o & rsp_ready_i;
    // Writes and errors carry no read data; whatever the macro drives is ignored.
    assign w_push_data = (r_pipe_we[Lat-1] | r_pipe_err[Lat-1]) ? '0 : sram_rdata_i;

    always_comb begin
        w_pipe_vld_d = (r_pipe_vld << 1) | Lat'(w_accept);
        w_pipe_we_d  = (r_pipe_we << 1) | Lat'(w_accept & req_we_i);
        w_pipe_err_d = (r_pipe_err << 1) | Lat'(w_accept & ~w_in_range);
        w_count_d    = r_count;
        unique case ({w_push, w_pop})
            2'b10:   w_count_d = r_count + CntWidth'(1);
            2'b01:   w_count_d = r_count - CntWidth'(1);
            default: w_count_d = r_count;
        endcase
        // Every accepted request reserves a FIFO slot until its response is popped.
        w_occ_d   = 32'(w_count_d) + 32'($countones(w_pipe_vld_d));
        w_ready_d = w_occ_d < RspFifoDepth;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ready    <= 1'b0;
            r_pipe_vld <= '0;
            r_pipe_we  <= '0;
            r_pipe_err <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_fifo_we  <= '0;
            r_fifo_err <= '0;
            for (int i = 0; i < int'(RspFifoDepth); i++) begin
                r_fifo_data[i] <= '0;
            end
        end else begin
            r_ready    <= w_ready_d;
            r_pipe_vld <= w_pipe_vld_d;
            r_pipe_we  <= w_pipe_we_d;
            r_pipe_err <= w_pipe_err_d;
            r_count    <= w_count_d;
            if (w_push) begin
                r_fifo_data[r_wptr] <= w_push_data;
                r_fifo_we[r_wptr]   <= r_pipe_we[Lat-1];
                r_fifo_err[r_wptr]  <= r_pipe_err[Lat-1];
                r_wptr              <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
        end
    end

    assign req_ready_o  = r_ready;
    assign rsp_valid_o  = (r_count != '0);
    assign rsp_rdata_o  = rsp_valid_o ? r_fifo_data[r_rptr] : '0;
    assign rsp_write_o  = rsp_valid_o & r_fifo_we[r_rptr];
    assign rsp_err_o    = rsp_valid_o & r_fifo_err[r_rptr];

    assign sram_req_o   = w_accept & w_in_range;
    assign sram_we_o    = sram_req_o & req_we_i;
    assign sram_addr_o  = sram_req_o ? req_addr_i : '0;
    assign sram_wdata_o = sram_req_o ? req_wdata_i : '0;
    assign sram_be_o    = sram_req_o ? (req_we_i ? req_strb_i : '1) : '0;

endmodule
